// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and its datapath/memory.
// The master side is the control unit; the slave side is the datapath.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic       alu_bcond;
    logic       halt_cond;
    logic       mem_ready;

    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_source;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;

    modport master (
        input  opcode, alu_bcond, halt_cond, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted
    );

    modport slave (
        output opcode, alu_bcond, halt_cond, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences IF/ID/EX/MEM/WB over a shared memory
// whose completion is either a ready strobe or a fixed-latency count.
module multicycle_control_fsm #(
    parameter int USE_MEM_READY = 1,
    parameter int MEM_LATENCY   = 1,
    parameter int CNT_W         = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_fsm_if.master    ctl
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADDR, S_MEM_RD, S_MEM_WR,
        S_WB_ALU, S_WB_MEM, S_BR, S_JAL, S_JALR, S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;

    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source;
    logic       reg_write, is_halted;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;

    assign done = (USE_MEM_READY != 0) ? ctl.mem_ready
                                       : (cnt_q == CNT_W'(MEM_LATENCY - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_source = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        is_halted = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (ctl.opcode)
                    OP_R:         state_d = S_EX_R;
                    OP_I:         state_d = S_EX_I;
                    OP_LD, OP_ST: state_d = S_EX_ADDR;
                    OP_BR:        state_d = S_BR;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_SYS:       state_d = ctl.halt_cond ? S_HALT : S_IF;
                    default:      state_d = S_IF;
                endcase
            end
            S_EX_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd2;
                state_d   = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 2'd2;
                state_d   = S_WB_ALU;
            end
            S_EX_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_d   = (ctl.opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (done) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (done) state_d = S_IF;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_IF;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
                state_d   = S_IF;
            end
            S_BR: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd1;
                pc_source = 1'b1;
                pc_write  = ctl.alu_bcond;
                state_d   = S_IF;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                pc_source = 1'b1;
                state_d   = S_IF;
            end
            S_JALR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT:  is_halted = 1'b1;
            default: state_d = S_IF;
        endcase
    end

    // The latency counter restarts whenever the FSM moves or an access completes.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || done) cnt_d = '0;
        else if (mem_read || mem_write)   cnt_d = cnt_q + 1'b1;
    end

    // While reset is held all outputs read zero, even though the state is IF.
    assign ctl.mem_read  = reset & mem_read;
    assign ctl.mem_write = reset & mem_write;
    assign ctl.i_or_d    = reset & i_or_d;
    assign ctl.ir_write  = reset & ir_write;
    assign ctl.pc_write  = reset & pc_write;
    assign ctl.pc_source = reset & pc_source;
    assign ctl.reg_write = reset & reg_write;
    assign ctl.is_halted = reset & is_halted;
    assign ctl.wb_sel    = reset ? wb_sel    : 2'd0;
    assign ctl.alu_src_a = reset ? alu_src_a : 2'd0;
    assign ctl.alu_src_b = reset ? alu_src_b : 2'd0;
    assign ctl.alu_op    = reset ? alu_op    : 2'd0;
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised multi-cycle control unit; successor to the single-cycle CPU's combinational control decode.
- Sequences each RV32I instruction through IF/ID/EX/MEM/WB states over a unified instruction/data memory.
- Memory latency is variable: either a ready handshake or a fixed-latency counter.
- Drives all datapath mux selects, write enables and memory strobes; owns the halt (ecall) condition.

Parameters:
- USE_MEM_READY, 1, 1 = memory ops complete on mem_ready; 0 = complete after MEM_LATENCY cycles (mem_ready ignored).
- MEM_LATENCY, 1, cycles per memory op when USE_MEM_READY=0; legal range 1..15.
- CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  7  instruction[6:0] from the instruction register.
- alu_bcond  in  1  branch-taken result from the ALU.
- halt_cond  in  1  1 when x17 == 10; evaluated only on ecall.
- mem_ready  in  1  memory completion strobe.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load instruction register and old_pc.
- pc_write  out  1  PC update enable.
- pc_source  out  1  next PC: 0 = ALU result, 1 = ALUOut register.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  rd data: 0 = ALUOut, 1 = MDR, 2 = PC.
- alu_src_a  out  2  0 = PC, 1 = A register, 2 = old_pc.
- alu_src_b  out  2  0 = B register, 1 = constant 4, 2 = immediate.
- alu_op  out  2  0 = add, 1 = branch compare, 2 = funct-decoded.
- is_halted  out  1  sticky halt flag.

Behaviour:
- Outputs are Moore-style decodes of state; the only Mealy terms are memory completion (done) and alu_bcond. Unlisted outputs are 0 in every state.
- done: mem_ready when USE_MEM_READY=1; else counter == MEM_LATENCY-1.
- Counter clears on every state change and on done; otherwise increments while mem_read or mem_write is high.
- Reset (asynchronous, reset=0): state = IF, counter = 0, is_halted = 0, all strobes 0. Reset mid-memory-op aborts the op; the first cycle after release is a fresh IF.
- IF:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0.
  - On done: ir_write=1, pc_write=1, pc_source=0, next state ID.
  - Otherwise hold IF.
- ID:
  - Outputs: alu_src_a=2, alu_src_b=2, alu_op=0 (ALUOut <= old_pc + imm).
  - Next state by opcode:
    - 0110011 -> EX_R.
    - 0010011 -> EX_I.
    - 0000011 / 0100011 -> EX_ADDR.
    - 1100011 -> BR.
    - 1101111 -> JAL.
    - 1100111 -> JALR.
    - 1110011 -> HALT if halt_cond=1, else IF.
    - Any other opcode -> IF (treated as NOP).
- EX_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> WB_ALU.
- EX_I: alu_src_a=1, alu_src_b=2, alu_op=2 -> WB_ALU.
- EX_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0 -> MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_read=1, i_or_d=1; on done -> WB_MEM, else hold.
- MEM_WR: mem_write=1, i_or_d=1; on done -> IF, else hold.
- WB_ALU: reg_write=1, wb_sel=0 -> IF.
- WB_MEM: reg_write=1, wb_sel=1 -> IF.
- BR: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1; pc_write = alu_bcond -> IF.
- JAL: reg_write=1, wb_sel=2, pc_write=1, pc_source=1 -> IF. The PC already holds PC+4, and the register write and PC update occur on the same edge.
- JALR: alu_src_a=1, alu_src_b=2, alu_op=0, reg_write=1, wb_sel=2, pc_write=1, pc_source=0 -> IF. The datapath clears bit 0 of the target.
- HALT:
  - is_halted=1, all strobes 0.
  - Absorbing state: leaves only via reset.
  - is_halted asserts the cycle after the ecall's ID cycle.
- Latency with one-cycle memory, in cycles: R/I = 4, load = 5, store = 4, branch = 3, JAL = 3, JALR = 3, ecall = 2. Each memory state adds (latency - 1) cycles.
- Strobes stay asserted and stable for the whole wait in a memory state.
- mem_ready arriving outside a memory state is ignored.

Test Plan:
- USE_MEM_READY=1, mem_ready tied 1, opcode=0110011 -> states IF,ID,EX_R,WB_ALU; reg_write high only in cycle 4; pc_write only in cycle 1.
- USE_MEM_READY=1, load, mem_ready low for 3 cycles in both IF and MEM_RD -> mem_read held 4 cycles in each; total 11 cycles; ir_write pulses exactly once.
- USE_MEM_READY=0, MEM_LATENCY=3, store -> mem_write high exactly 3 cycles; total 8 cycles; mem_ready toggling is ignored.
- Branch with alu_bcond=0, then a branch with alu_bcond=1 -> BR-state pc_write is 0 and then 1; pc_source=1 in both.
- opcode=1110011 with halt_cond=0 -> returns to IF, is_halted=0. Repeat with halt_cond=1 -> is_halted=1 from the next cycle and stays 1 for 20 cycles with no strobes.
- reset pulled low during MEM_RD wait -> outputs go to reset values immediately (asynchronously); after release the FSM is in IF with mem_read=1, i_or_d=0, and is_halted cleared.
